// File: rtl/servo_spi_master.sv
// SPI mode-0 master that sends two-byte servo frames ({2'b00,num} then pos, MSB first)
// and returns the MISO byte clocked in during the second byte.
module servo_spi_master #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] cmd_num,
    input  logic [7:0] cmd_pos,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       spi_ss,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [4:0]       bit_q, bit_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [15:0]      shift_q, shift_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             done_q, done_d;
    logic             ss_q, ss_d;
    logic             sck_q, sck_d;
    logic             mosi_q, mosi_d;
    logic [4:0]       next_bit;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        gap_d      = gap_q;
        shift_d    = shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        done_d     = 1'b0;
        ss_d       = ss_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        next_bit   = bit_q + 5'd1;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_SETUP;
                    shift_d = {2'b00, cmd_num, cmd_pos};
                    mosi_d  = 1'b0;
                    ss_d    = 1'b0;
                    sck_d   = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            ST_SETUP: begin
                if (div_q == DIV_MAX) begin
                    state_d = ST_SHIFT;
                    div_d   = '0;
                    sck_d   = 1'b1;
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            ST_SHIFT: begin
                if (div_q != DIV_MAX) begin
                    div_d = div_q + DIV_ONE;
                end else begin
                    div_d = '0;
                    if (sck_q) begin
                        // The last bit stays on MOSI through HOLD, so no advance after bit 15.
                        sck_d = 1'b0;
                        if (bit_q != 5'd15) begin
                            shift_d = {shift_q[14:0], 1'b0};
                            mosi_d  = shift_q[14];
                        end
                    end else if (bit_q == 5'd15) begin
                        state_d = ST_HOLD;
                    end else begin
                        bit_d = next_bit;
                        sck_d = 1'b1;
                        if (next_bit[3]) begin
                            rx_shift_d = {rx_shift_q[6:0], spi_miso};
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (div_q == DIV_MAX) begin
                    state_d = ST_GAP;
                    div_d   = '0;
                    gap_d   = '0;
                    ss_d    = 1'b1;
                    mosi_d  = 1'b0;
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            ST_GAP: begin
                // First GAP cycle publishes the result, then GAP_CYCLES more before IDLE.
                if (gap_q == '0) begin
                    done_d    = 1'b1;
                    rx_data_d = rx_shift_q;
                end
                if (gap_q == GAP_MAX) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ss_d    = 1'b1;
                sck_d   = 1'b0;
                mosi_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            gap_q      <= '0;
            shift_q    <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            done_q     <= 1'b0;
            ss_q       <= 1'b1;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            gap_q      <= gap_d;
            shift_q    <= shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            done_q     <= done_d;
            ss_q       <= ss_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign done      = done_q;
    assign rx_data   = rx_data_q;
    assign spi_ss    = ss_q;
    assign spi_sck   = sck_q;
    assign spi_mosi  = mosi_q;

endmodule

// File: tb/tb_servo_spi_master.sv
// Randomized self-checking bench for servo_spi_master: a frame-level monitor and
// slave model check each frame against the command word and slave byte.
module tb_servo_spi_master;

    localparam int CLK_DIV    = 4;
    localparam int GAP_CYCLES = 8;
    localparam int SS_LOW     = 34 * CLK_DIV;
    localparam int PERIOD     = 34 * CLK_DIV + GAP_CYCLES + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] cmd_num = '0;
    logic [7:0] cmd_pos = '0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       done;
    logic [7:0] rx_data;
    logic       spi_ss;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    servo_spi_master #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_num(cmd_num), .cmd_pos(cmd_pos),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .done(done), .rx_data(rx_data),
        .spi_ss(spi_ss), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame-level reference: what a mode-0 slave would see, compared per frame.
    logic [15:0] exp_q[$];
    int          cyc = 0;
    int          low_cnt = 0;
    int          rises = 0;
    logic [15:0] bits = '0;
    int          ss_rise_cyc = -100;
    int          last_acc = 0;
    bit          prev_cont = 1'b0;
    bit          spacing_check = 1'b0;
    bit          abort_pending = 1'b0;
    bit          force_en = 1'b0;
    logic [7:0]  forced_byte = 8'h00;
    logic [7:0]  slave_byte = 8'h00;
    logic [7:0]  exp_rx = 8'h00;
    int          acc_cnt = 0;
    int          done_cnt = 0;
    logic        prev_ss = 1'b1;
    logic        prev_sck = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n && cmd_valid && cmd_ready) begin
            if (spacing_check && prev_cont)
                checkOutput("accept_spacing", cyc + 1 - last_acc, PERIOD);
            prev_cont  = spacing_check;
            last_acc   = cyc + 1;
            acc_cnt++;
            exp_q.push_back({2'b00, cmd_num, cmd_pos});
            slave_byte = force_en ? forced_byte : 8'($urandom);
            low_cnt    = 0;
            rises      = 0;
            bits       = '0;
        end
        if (!spi_ss) low_cnt++;
        if (spi_sck && !prev_sck) begin
            rises++;
            bits = {bits[14:0], spi_mosi};
        end
        if (spi_ss && !prev_ss) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_frame", 0, 1);
            end else if (abort_pending) begin
                void'(exp_q.pop_front());
                abort_pending = 1'b0;
            end else begin
                checkOutput("ss_low_cycles", low_cnt, SS_LOW);
                checkOutput("sck_rises", rises, 16);
                checkOutput("mosi_word", bits, exp_q.pop_front());
                exp_rx      = slave_byte;
                ss_rise_cyc = cyc;
            end
        end
        if (done) begin
            done_cnt++;
            checkOutput("done_after_ss", cyc - ss_rise_cyc, 1);
            checkOutput("rx_data", rx_data, exp_rx);
        end
        if (!spi_ss && rises >= 8 && rises <= 15)
            spi_miso = slave_byte[15 - rises];
        else
            spi_miso = 1'($urandom);
        prev_ss  = spi_ss;
        prev_sck = spi_sck;
    end

    task automatic applyStimulus(input logic [5:0] n, input logic [7:0] p, input bit wait_done);
        int t;
        int d0;
        d0 = done_cnt;
        cmd_num   = n;
        cmd_pos   = p;
        cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 500) begin
            @(posedge clk); #1; t++;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_num   = 6'($urandom);
        cmd_pos   = 8'($urandom);
        if (wait_done) begin
            t = 0;
            while (done_cnt == d0 && t < 400) begin
                @(posedge clk); #1; t++;
            end
            checkOutput("frame_done", done_cnt - d0, 1);
        end
    endtask

    int frames = 0;

    initial begin
        int t;
        int d0;
        int target;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        checkOutput("reset_ss", spi_ss, 1);
        checkOutput("reset_sck", spi_sck, 0);
        checkOutput("reset_mosi", spi_mosi, 0);
        checkOutput("reset_ready", cmd_ready, 1);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_rx", rx_data, 0);

        applyStimulus(6'd5, 8'h80, 1'b1);
        frames++;

        force_en = 1'b1;
        forced_byte = 8'hA5;
        applyStimulus(6'd63, 8'hFF, 1'b1);
        frames++;
        force_en = 1'b0;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(6'($urandom), 8'($urandom), 1'b1);
            frames++;
        end

        // Back-to-back: valid held high while the data wanders every cycle.
        spacing_check = 1'b1;
        target = acc_cnt + 4;
        cmd_valid = 1'b1;
        t = 0;
        while (acc_cnt < target && t < 1000) begin
            cmd_num = 6'($urandom);
            cmd_pos = 8'($urandom);
            @(posedge clk); #1; t++;
        end
        cmd_valid = 1'b0;
        spacing_check = 1'b0;
        checkOutput("continuous_accepts", acc_cnt, target);
        frames += 4;
        t = 0;
        while ((exp_q.size() != 0 || done_cnt != frames) && t < 400) begin
            @(posedge clk); #1; t++;
        end
        checkOutput("continuous_done", done_cnt, frames);

        // Abort during bit 9 of the shift.
        applyStimulus(6'($urandom), 8'($urandom), 1'b0);
        t = 0;
        while (rises < 10 && t < 400) begin
            @(posedge clk); #1; t++;
        end
        checkOutput("reach_bit9", rises, 10);
        d0 = done_cnt;
        abort_pending = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort_ss", spi_ss, 1);
        checkOutput("abort_sck", spi_sck, 0);
        checkOutput("abort_ready", cmd_ready, 1);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_rx", rx_data, 0);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1 checkOutput("abort_no_done", done_cnt, d0);

        applyStimulus(6'd12, 8'h3C, 1'b1);
        frames++;
        applyStimulus(6'($urandom), 8'($urandom), 1'b1);
        frames++;

        checkOutput("total_done", done_cnt, frames);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
